dmem_arbiter: RTL

//  Shares the single-port data memory between the core MEM stage and a loader/debug port.

---
 rtl/dmem_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the core MEM stage and a loader/debug port.
// The core has priority, but a starvation counter forces a loader grant after STARVE_MAX denials.
module dmem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 9,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_rd,
  input  logic              core_wr,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wr_data,
  output logic              core_stall,
  output logic              core_rd_valid,
  output logic [DATA_W-1:0] core_rd_data,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wr_data,
  output logic              ldr_gnt,
  output logic              ldr_rd_valid,
  output logic [DATA_W-1:0] ldr_rd_data,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CORE = 2'd1;
  localparam logic [1:0] OWN_LDR  = 2'd2;
  localparam int         SC_W     = 4;
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);

  logic [SC_W-1:0]  starve_cnt;
  logic [1:0]       rsp_own;
  logic [1:0]       owner;
  logic [CNT_W-1:0] stall_cnt;
  logic             core_act;
  logic             force_ldr;

  // Owner selection; reset suppresses every grant so all strobes fall to zero.
  always_comb begin
    core_act  = core_rd | core_wr;
    force_ldr = (starve_cnt == SC_MAX);
    owner     = OWN_NONE;
    if (reset) begin
      owner = OWN_NONE;
    end else if (ldr_req && (!core_act || force_ldr)) begin
      owner = OWN_LDR;
    end else if (core_act) begin
      owner = OWN_CORE;
    end else begin
      owner = OWN_NONE;
    end
  end

  // Memory mux; a simultaneous core read+write is treated as a write only.
  always_comb begin
    ldr_gnt     = 1'b0;
    core_stall  = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    case (owner)
      OWN_CORE: begin
        mem_wr      = core_wr;
        mem_rd      = core_rd & ~core_wr;
        mem_addr    = core_addr;
        mem_wr_data = core_wr_data;
      end
      OWN_LDR: begin
        ldr_gnt     = 1'b1;
        core_stall  = core_act;
        mem_wr      = ldr_we;
        mem_rd      = ~ldr_we;
        mem_addr    = ldr_addr;
        mem_wr_data = ldr_wr_data;
      end
      default: begin
        mem_rd = 1'b0;
        mem_wr = 1'b0;
      end
    endcase
  end

  // Consecutive loader denials, saturating at the forcing threshold.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (ldr_gnt || !ldr_req) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SC_MAX) begin
      starve_cnt <= starve_cnt + SC_W'(1);
    end else begin
      starve_cnt <= starve_cnt;
    end
  end

  // Remember which side issued the read so next-cycle data is routed back to it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_own <= OWN_NONE;
    end else if (mem_rd) begin
      rsp_own <= owner;
    end else begin
      rsp_own <= OWN_NONE;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (core_stall && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

  // Response routing and output gating during reset.
  always_comb begin
    core_rd_valid = !reset && (rsp_own == OWN_CORE);
    ldr_rd_valid  = !reset && (rsp_own == OWN_LDR);
    core_rd_data  = core_rd_valid ? mem_rd_data : '0;
    ldr_rd_data   = ldr_rd_valid ? mem_rd_data : '0;
    stall_cycles  = reset ? '0 : stall_cnt;
  end

endmodule
